// File: rtl/uart_pkg.sv
// Shared UART receive definitions: RX state encoding, legal prescale values
// and a majority-vote helper.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
package uart_pkg;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  localparam int unsigned RX_STATE_W = 3;

  typedef enum logic [RX_STATE_W-1:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    RX_PARITY = 3'd3,
`endif
    RX_STOP   = 3'd4,
    RX_DONE   = 3'd5
  } rx_state_e;

  // Two-out-of-three vote used to filter each received bit.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // True when a prescale value is one of the supported oversampling ratios.
  function automatic logic is_legal_prescale(input int unsigned p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with three mid-bit samples and a majority vote.
// The counter runs while 'run' is high and wraps at prescale-1; outside a
// frame it is held at zero so every frame starts on count 0.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_in,
  input  logic                      run,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_end_c,
  output logic                      sampled_bit
);

  localparam int unsigned PW = PRESCALE_WIDTH;

  logic [PW-1:0] edge_cnt_q, edge_cnt_d;
  logic [PW-1:0] half_c, last_c;
  logic [1:0]    samp_q, samp_d;
  logic          bit_q, bit_d;

  assign half_c      = prescale >> 1;
  assign last_c      = prescale - PW'(1);
  assign bit_end_c   = run && (edge_cnt_q == last_c);
  assign sampled_bit = bit_q;

  // Edge counting, sample capture around mid-bit and the vote on the third sample.
  always_comb begin
    edge_cnt_d = '0;
    samp_d     = samp_q;
    bit_d      = bit_q;
    if (run) begin
      edge_cnt_d = bit_end_c ? '0 : edge_cnt_q + PW'(1);
      if (edge_cnt_q == half_c - PW'(1)) samp_d[0] = rx_in;
      if (edge_cnt_q == half_c)          samp_d[1] = rx_in;
      if (edge_cnt_q == half_c + PW'(1)) bit_d = maj3(samp_q[0], samp_q[1], rx_in);
    end
  end

  // Sampler state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_q <= '0;
      samp_q     <= 2'b11;
      bit_q      <= 1'b1;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      samp_q     <= samp_d;
      bit_q      <= bit_d;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: start/data/[parity]/stop framing with majority-vote
// sampling and one-cycle result pulses.
// Optional feature macro: UART_RX_PARITY_EN compiles in the parity bit
// capture and check; without it PAR_EN/PAR_TYP are ignored and PAR_ERR is 0.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_LENGTH    = 8,
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [DATA_LENGTH-1:0]    P_DATA,
  output logic                      DATA_VALID,
  output logic                      PAR_ERR,
  output logic                      STP_ERR
);

  localparam int unsigned DL        = DATA_LENGTH;
  localparam int unsigned PW        = PRESCALE_WIDTH;
  localparam int unsigned BIT_CNT_W = (DL > 1) ? $clog2(DL) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DL - 1);

  rx_state_e            state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DL-1:0]        shift_q, shift_d;
  logic [PW-1:0]        prescale_q, prescale_d;
  logic                 armed_q, armed_d;
  logic [DL-1:0]        p_data_q, p_data_d;
  logic                 data_valid_q, data_valid_d;
  logic                 stp_err_q, stp_err_d;
  logic                 start_frame_c;
  logic                 run_c;
  logic                 bit_end_c;
  logic                 sampled_bit;

`ifdef UART_RX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_typ_q, par_typ_d;
  logic par_bad_q, par_bad_d;
  logic par_err_q, par_err_d;
`else
  logic unused_par_c;
  assign unused_par_c = PAR_EN ^ PAR_TYP;
`endif

  assign run_c = (state_q != RX_IDLE);

  uart_rx_sampler #(
    .PRESCALE_WIDTH(PW)
  ) u_sampler (
    .clk        (CLK),
    .rst_n      (RST),
    .rx_in      (RX_IN),
    .run        (run_c),
    .prescale   (prescale_q),
    .bit_end_c  (bit_end_c),
    .sampled_bit(sampled_bit)
  );

  // Next-state, frame assembly and result-pulse logic.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    prescale_d    = prescale_q;
    // Only a line seen high since reset may start a frame, so a frame cut by
    // reset is ignored until the line returns to idle.
    armed_d       = armed_q | RX_IN;
    p_data_d      = p_data_q;
    data_valid_d  = 1'b0;
    stp_err_d     = 1'b0;
    start_frame_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en_d      = par_en_q;
    par_typ_d     = par_typ_q;
    par_bad_d     = par_bad_q;
    par_err_d     = 1'b0;
`endif

    case (state_q)
      RX_IDLE: begin
        if (armed_q && !RX_IN) begin
          state_d       = RX_START;
          start_frame_c = 1'b1;
        end
      end
      RX_START: begin
        if (bit_end_c) begin
          state_d = sampled_bit ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bit_end_c) begin
          shift_d         = shift_q >> 1;
          shift_d[DL-1]   = sampled_bit;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = par_en_q ? RX_PARITY : RX_STOP;
`else
            state_d = RX_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (bit_end_c) begin
          par_bad_d = sampled_bit != ((^shift_q) ^ par_typ_q);
          state_d   = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (bit_end_c) begin
          state_d   = RX_DONE;
          stp_err_d = !sampled_bit;
`ifdef UART_RX_PARITY_EN
          par_err_d    = par_bad_q;
          data_valid_d = sampled_bit && !par_bad_q;
`else
          data_valid_d = sampled_bit;
`endif
          if (data_valid_d) p_data_d = shift_q;
        end
      end
      RX_DONE: begin
        if (!RX_IN) begin
          state_d       = RX_START;
          start_frame_c = 1'b1;
        end else begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase

    // Frame configuration is captured once per frame, at entry to START.
    if (start_frame_c) begin
      prescale_d = PRESCALE;
      bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
      par_en_d   = PAR_EN;
      par_typ_d  = PAR_TYP;
      par_bad_d  = 1'b0;
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= RX_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      prescale_q   <= PW'(PRESCALE_8);
      armed_q      <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      prescale_q   <= prescale_d;
      armed_q      <= armed_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      stp_err_q    <= stp_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity configuration and result registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bad_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_bad_q <= par_bad_d;
      par_err_q <= par_err_d;
    end
  end

  assign PAR_ERR = par_err_q;
`else
  assign PAR_ERR = 1'b0;
`endif

  assign P_DATA     = p_data_q;
  assign DATA_VALID = data_valid_q;
  assign STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed frames plus randomized traffic, checked
// against a frame-level model of expected result pulses (cycle, flags, data).
module tb_uart_rx_core;

  localparam int DL = 8;
  localparam int PW = 6;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx;
  logic [PW-1:0] pres;
  logic          par_en;
  logic          par_typ;
  logic [DL-1:0] p_data;
  logic          dv;
  logic          pe;
  logic          se;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int            cyc;
    logic          dv;
    logic          pe;
    logic          se;
    logic [DL-1:0] pd;
  } ev_t;

  ev_t           obs_q[$];
  ev_t           exp_q[$];
  logic [DL-1:0] model_pd;

  uart_rx_core #(
    .DATA_LENGTH   (DL),
    .PRESCALE_WIDTH(PW)
  ) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .RX_IN     (rx),
    .PRESCALE  (pres),
    .PAR_EN    (par_en),
    .PAR_TYP   (par_typ),
    .P_DATA    (p_data),
    .DATA_VALID(dv),
    .PAR_ERR   (pe),
    .STP_ERR   (se)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every result pulse with its edge number.
  always @(negedge clk) begin
    if (rst_n && (dv || pe || se)) obs_q.push_back('{cyc, dv, pe, se, p_data});
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame from a negedge; the model predicts the result pulse.
  task automatic send_frame(input logic [DL-1:0] d, input int p, input logic pen,
                            input logic ptyp, input logic bad_par, input logic stop_b);
    int   start;
    bit   par_on;
    logic exp_pe, exp_se, exp_dv;
    par_on  = pen && PAR_BUILT;
    pres    = PW'(p);
    par_en  = pen;
    par_typ = ptyp;
    start   = cyc + 1;
    rx      = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < DL; i++) begin
      rx = d[i];
      if (i == 0) begin
        // Configuration changes mid-frame must not affect this frame.
        pres    = PW'((p == 8) ? 32 : 8);
        par_en  = ~pen;
        par_typ = ~ptyp;
      end
      repeat (p) @(negedge clk);
    end
    if (par_on) begin
      rx = (^d) ^ ptyp ^ bad_par;
      repeat (p) @(negedge clk);
    end
    rx = stop_b;
    repeat (p) @(negedge clk);
    exp_pe = par_on && bad_par;
    exp_se = !stop_b;
    exp_dv = !exp_pe && !exp_se;
    if (exp_dv) model_pd = d;
    exp_q.push_back('{start + (2 + DL + (par_on ? 1 : 0)) * p, exp_dv, exp_pe, exp_se, model_pd});
  endtask

  task automatic check_events(input string tag);
    chk({tag, ".count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk($sformatf("%s[%0d].cyc", tag, i), 32'(obs_q[i].cyc), 32'(exp_q[i].cyc));
      chk($sformatf("%s[%0d].dv",  tag, i), 32'(obs_q[i].dv),  32'(exp_q[i].dv));
      chk($sformatf("%s[%0d].pe",  tag, i), 32'(obs_q[i].pe),  32'(exp_q[i].pe));
      chk($sformatf("%s[%0d].se",  tag, i), 32'(obs_q[i].se),  32'(exp_q[i].se));
      chk($sformatf("%s[%0d].pd",  tag, i), 32'(obs_q[i].pd),  32'(exp_q[i].pd));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int            p;
    int            gap;
    logic [DL-1:0] d;
    logic          pen, ptyp, bad, stop_b;

    rst_n    = 1'b0;
    rx       = 1'b1;
    pres     = PW'(8);
    par_en   = 1'b0;
    par_typ  = 1'b0;
    model_pd = '0;
    repeat (3) @(negedge clk);
    chk("reset.p_data", 32'(p_data), 32'(0));
    chk("reset.dv",     32'(dv),     32'(0));
    chk("reset.pe",     32'(pe),     32'(0));
    chk("reset.se",     32'(se),     32'(0));
    rst_n = 1'b1;
    idle(4);

    // Plain 8x frame, result 80 edges after the start edge.
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(6);
    check_events("basic");

    // Even parity, good then corrupted parity bit.
    send_frame(8'h55, 16, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(6);
    send_frame(8'h55, 16, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(6);
    check_events("even_par");
    chk("even_par.hold", 32'(p_data), 32'(model_pd));

    // Odd parity with a broken stop bit.
    send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(6);
    check_events("stop_err");

    // Short low glitch, then a normal frame.
    pres = PW'(8);
    rx   = 1'b0;
    repeat (2) @(negedge clk);
    idle(30);
    check_events("glitch");
    send_frame(8'h81, 16, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(6);
    check_events("after_glitch");

    // Back-to-back frames with no idle gap.
    send_frame(8'hA5, 32, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h3C, 32, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(8);
    chk("b2b.gap", 32'((obs_q.size() >= 2) ? (obs_q[1].cyc - obs_q[0].cyc) : -1), 32'(320));
    check_events("b2b");

    // Randomized traffic.
    for (int k = 0; k < 16; k++) begin
      case ($urandom_range(0, 2))
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      d      = DL'($urandom);
      pen    = 1'($urandom_range(0, 1));
      ptyp   = 1'($urandom_range(0, 1));
      bad    = ($urandom_range(0, 3) == 0);
      stop_b = ($urandom_range(0, 4) != 0);
      send_frame(d, p, pen, ptyp, bad, stop_b);
      gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 12));
      if (gap > 0) idle(gap);
    end
    idle(8);
    check_events("rand");

    // Reset in the middle of data bit 4, line still low after release.
    pres   = PW'(8);
    par_en = 1'b0;
    rx     = 1'b0;
    repeat (8 + 4 * 8 + 3) @(negedge clk);
    rst_n    = 1'b0;
    model_pd = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("in_rst[%0d].p_data", i), 32'(p_data), 32'(0));
      chk($sformatf("in_rst[%0d].dv", i),     32'(dv),     32'(0));
      chk($sformatf("in_rst[%0d].pe", i),     32'(pe),     32'(0));
      chk($sformatf("in_rst[%0d].se", i),     32'(se),     32'(0));
    end
    rst_n = 1'b1;
    rx    = 1'b0;
    repeat (12) @(negedge clk);
    idle(100);
    check_events("rst_tail");
    chk("rst_tail.p_data", 32'(p_data), 32'(0));
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(6);
    check_events("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
